pie_decoder: RTL and testbench
==============================

// Module: pie_decoder
// PURPOSE
//  Decodes the raw reader-to-tag PIE envelope (i_pie) into a framed bit stream for tag_digital_core.
//  Sits directly upstream of the core: detects delimiter, measures Tari/RTcal/TRcal, slices data symbols.
//  Emits frame start (preamble vs frame-sync), per-bit strobes, end-of-frame and error pulses.
// PARAMETERS
//  CNT_W      10  width of interval counters (saturating), in clk cycles
//  DELIM_MIN  20  min delimiter low width accepted (cycles, inclusive)
//  DELIM_MAX  30  max delimiter low width accepted (cycles, inclusive)
//  TARI_MIN   10  min data-0 (Tari) interval accepted (inclusive)
//  TARI_MAX   50  max data-0 (Tari) interval accepted (inclusive)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous, active-high reset
//  i_pie       in   1      raw demodulated envelope, asynchronous to clk, idle high
//  o_bit       out  1      decoded data bit, valid with o_bit_vld
//  o_bit_vld   out  1      1-cycle strobe per decoded symbol
//  o_sof       out  1      1-cycle strobe: calibration complete, frame data follows
//  o_preamble  out  1      1 = frame had TRcal (Query preamble); held until next o_sof
//  o_eof       out  1      1-cycle strobe: frame ended (no rising edge within RTcal)
//  o_err       out  1      1-cycle strobe: calibration out of range or counter saturated
//  o_rtcal     out  CNT_W  last measured RTcal, held
//  o_trcal     out  CNT_W  last measured TRcal (valid when o_preamble), held
// BEHAVIOUR
//  - One clock; reset asynchronous active-high. Reset: sync flops=1, state=IDLE, all strobes/o_bit/o_preamble=0, o_rtcal=o_trcal=0.
//  - Input path: 2-flop synchroniser + previous-sample flop; rise = s2 & ~s3. All outputs registered.
//  - Latency: i_pie rising edge -> o_bit_vld/o_sof 3 clk.
//  - cnt: cleared on each rise, +1 otherwise, saturates at 2^CNT_W-1. lo_cnt: counts while line low, cleared on rise; runs in every state.
//  - States: IDLE -> TARI -> RTCAL -> CAL -> DATA -> IDLE.
//    IDLE: on rise, if DELIM_MIN<=lo_cnt<=DELIM_MAX -> TARI; else stay, no error.
//    TARI: on rise, tari=cnt; out of [TARI_MIN,TARI_MAX] -> o_err, IDLE; else RTCAL.
//    RTCAL: on rise, rtcal=cnt; require 2*tari<=rtcal<=4*tari else o_err, IDLE; pivot=rtcal>>1; -> CAL.
//    CAL: on rise, if cnt>rtcal: o_trcal=cnt, o_preamble=1, o_sof, -> DATA.
//         else frame-sync: o_preamble=0, o_sof AND first bit (cnt>pivot) with o_bit_vld same cycle, -> DATA.
//         cnt saturates in CAL -> o_err, IDLE.
//    DATA: on rise, o_bit=(cnt>pivot), o_bit_vld. No rise by cnt==rtcal+1 -> o_eof, IDLE.
//  - Simultaneous rise and EOF/saturation condition: rise wins (symbol decoded, no o_eof/o_err).
//  - Delimiter after a frame: lo_cnt runs independently, so a delimiter overlapping EOF is still caught.
//  - Any delimiter-qualified rise in non-IDLE states is decoded as a symbol (no mid-frame resync).
//  - Comparisons unsigned; 2*tari and 4*tari computed at CNT_W+2 bits, no overflow.
//  - Reset mid-frame: immediate return to IDLE, no o_eof.
// CONFIGURATION
//  PIE_GLITCH_FILTER_EN defined: 3-sample majority filter (registered) after synchroniser; pulses <2 clk rejected; latency 5 clk.
//  Undefined: no filter, latency 3 clk, single-cycle glitches produce edges.
// STRUCTURE
//  tag_pie_pkg: state encoding (IDLE/TARI/RTCAL/CAL/DATA), CNT_W default, default limits.
//  Sub-module pie_sync_edge: synchroniser, optional majority filter, rise detect; outputs s_level, rise.
//  Top: counters, FSM, calibration registers, output regs.
// TESTING
//  1 low 24, Tari 12, RTcal 33, TRcal 80, bits 0,1,1,0 (12,20,20,12) -> o_sof+o_preamble=1, o_trcal=80, o_rtcal=33, bits 0110, o_eof 34 clk after last rise.
//  2 same without TRcal, first symbol 20 -> o_sof with o_preamble=0 and o_bit=1 same cycle; no o_trcal update.
//  3 delimiter 15 or 40 low -> no state change, no o_err; next 24 low delimiter frame decodes normally.
//  4 Tari 60 -> o_err 3 clk after rise, IDLE; RTcal 20 with Tari 12 -> o_err.
//  5 rst asserted mid-DATA -> all outputs 0 immediately, no o_eof; subsequent frame decodes.
//  6 with PIE_GLITCH_FILTER_EN, 1-clk low glitch inside data-1 -> ignored, bit still 1; without macro -> extra symbol.

Source files
------------

// File: rtl/tag_pie_pkg.sv
// Shared PIE decoder types: FSM state encoding, default counter width and limits.
// Build option PIE_GLITCH_FILTER_EN (see pie_sync_edge) adds a majority filter.
package tag_pie_pkg;

  localparam int PIE_CNT_W     = 10;
  localparam int PIE_DELIM_MIN = 20;
  localparam int PIE_DELIM_MAX = 30;
  localparam int PIE_TARI_MIN  = 10;
  localparam int PIE_TARI_MAX  = 50;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TARI  = 3'd1,
    ST_RTCAL = 3'd2,
    ST_CAL   = 3'd3,
    ST_DATA  = 3'd4
  } pie_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pie_sync_edge.sv
// Brings the asynchronous PIE envelope into clk, optionally majority-filters it
// (PIE_GLITCH_FILTER_EN) and flags rising edges of the clean level.
module pie_sync_edge
  import tag_pie_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_pie,
  output logic s_level,
  output logic rise
);

  logic [1:0] sync;
  logic       lvl_q;

  // Line idles high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], i_pie};
  end

`ifdef PIE_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  // Two of three consecutive samples must agree, so a one-cycle pulse never passes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 2'b11;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], sync[1]};
      filt <= maj3(sync[1], hist[0], hist[1]);
    end
  end

  assign s_level = filt;
`else
  assign s_level = sync[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lvl_q <= 1'b1;
    else     lvl_q <= s_level;
  end

  assign rise = s_level & ~lvl_q;

endmodule

// File: rtl/pie_decoder.sv
// PIE envelope decoder: delimiter detect, Tari/RTcal/TRcal calibration, symbol slicing.
// Build option PIE_GLITCH_FILTER_EN lengthens edge latency from 3 to 5 clk.
module pie_decoder
  import tag_pie_pkg::*;
#(
  parameter int CNT_W     = PIE_CNT_W,
  parameter int DELIM_MIN = PIE_DELIM_MIN,
  parameter int DELIM_MAX = PIE_DELIM_MAX,
  parameter int TARI_MIN  = PIE_TARI_MIN,
  parameter int TARI_MAX  = PIE_TARI_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pie,
  output logic             o_bit,
  output logic             o_bit_vld,
  output logic             o_sof,
  output logic             o_preamble,
  output logic             o_eof,
  output logic             o_err,
  output logic [CNT_W-1:0] o_rtcal,
  output logic [CNT_W-1:0] o_trcal
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DMIN    = CNT_W'(DELIM_MIN);
  localparam logic [CNT_W-1:0] DMAX    = CNT_W'(DELIM_MAX);
  localparam logic [CNT_W-1:0] TMIN    = CNT_W'(TARI_MIN);
  localparam logic [CNT_W-1:0] TMAX    = CNT_W'(TARI_MAX);

  logic             s_level, rise;
  logic [CNT_W-1:0] cnt, lo_cnt, tari, pivot;
  logic [CNT_W+1:0] cnt_x, tari_x2, tari_x4;
  logic [CNT_W:0]   rt_p1;
  logic             cnt_sat, delim_ok, tari_ok, rt_ok, trcal_seen, sym_bit, eof_hit;
  logic             bit_d, bit_vld_d, sof_d, eof_d, err_d;
  pie_state_e       state, state_nxt;

  pie_sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pie   (i_pie),
    .s_level (s_level),
    .rise    (rise)
  );

  // cnt restarts at 1 so its value at the next rise equals the rise-to-rise interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      lo_cnt <= '0;
    end else begin
      if (rise)              cnt <= CNT_W'(1);
      else if (!cnt_sat)     cnt <= cnt + CNT_W'(1);
      if (rise)                               lo_cnt <= '0;
      else if (!s_level && lo_cnt != CNT_MAX) lo_cnt <= lo_cnt + CNT_W'(1);
    end
  end

  assign cnt_sat    = (cnt == CNT_MAX);
  assign delim_ok   = (lo_cnt >= DMIN) && (lo_cnt <= DMAX);
  assign tari_ok    = (cnt >= TMIN) && (cnt <= TMAX);
  assign cnt_x      = {2'b00, cnt};
  assign tari_x2    = {1'b0, tari, 1'b0};
  assign tari_x4    = {tari, 2'b00};
  assign rt_ok      = (cnt_x >= tari_x2) && (cnt_x <= tari_x4);
  assign pivot      = o_rtcal >> 1;
  assign trcal_seen = (cnt > o_rtcal);
  assign sym_bit    = (cnt > pivot);
  assign rt_p1      = {1'b0, o_rtcal} + {{CNT_W{1'b0}}, 1'b1};
  assign eof_hit    = ({1'b0, cnt} >= rt_p1) || cnt_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A rise always takes priority over timeout/saturation in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (rise && delim_ok) state_nxt = ST_TARI;
      ST_TARI:  if (rise)             state_nxt = tari_ok ? ST_RTCAL : ST_IDLE;
                else if (cnt_sat)     state_nxt = ST_IDLE;
      ST_RTCAL: if (rise)             state_nxt = rt_ok ? ST_CAL : ST_IDLE;
                else if (cnt_sat)     state_nxt = ST_IDLE;
      ST_CAL:   if (rise)             state_nxt = ST_DATA;
                else if (cnt_sat)     state_nxt = ST_IDLE;
      ST_DATA:  if (!rise && eof_hit) state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bit_vld_d = rise && ((state == ST_DATA) || (state == ST_CAL && !trcal_seen));
    bit_d     = bit_vld_d ? sym_bit : o_bit;
    sof_d     = rise && (state == ST_CAL);
    eof_d     = !rise && (state == ST_DATA) && eof_hit;
    err_d     = (rise && state == ST_TARI && !tari_ok) ||
                (rise && state == ST_RTCAL && !rt_ok) ||
                (!rise && cnt_sat &&
                 (state == ST_TARI || state == ST_RTCAL || state == ST_CAL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_bit     <= 1'b0;
      o_bit_vld <= 1'b0;
      o_sof     <= 1'b0;
      o_eof     <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_bit     <= bit_d;
      o_bit_vld <= bit_vld_d;
      o_sof     <= sof_d;
      o_eof     <= eof_d;
      o_err     <= err_d;
    end
  end

  // o_rtcal tracks every RTcal measurement; o_trcal only changes on a preamble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tari       <= '0;
      o_rtcal    <= '0;
      o_trcal    <= '0;
      o_preamble <= 1'b0;
    end else if (rise) begin
      if (state == ST_TARI)  tari    <= cnt;
      if (state == ST_RTCAL) o_rtcal <= cnt;
      if (state == ST_CAL) begin
        o_preamble <= trcal_seen;
        if (trcal_seen) o_trcal <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_pie_decoder.sv
// Self-checking bench for pie_decoder: directed and random PIE frames against a
// rise-time based frame model.
module tb_pie_decoder;

`ifdef PIE_GLITCH_FILTER_EN
  localparam int LAT  = 5;
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 3;
  localparam bit FILT = 1'b0;
`endif
  localparam int MAXC = 40000;

  typedef struct {
    int iv;
    int pw;
    int g;
  } sym_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_pie;
  logic       o_bit, o_bit_vld, o_sof, o_preamble, o_eof, o_err;
  logic [9:0] o_rtcal, o_trcal;

  bit   wave[$];
  sym_t sq[$];
  bit   e_vld[MAXC], e_bit[MAXC], e_sof[MAXC], e_pre[MAXC], e_eof[MAXC], e_err[MAXC];
  int   e_rt[MAXC], e_tr[MAXC];
  int   ptr = 0, n_chk = 0, n_pass = 0, last_tr = 0;

  pie_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .i_pie      (i_pie),
    .o_bit      (o_bit),
    .o_bit_vld  (o_bit_vld),
    .o_sof      (o_sof),
    .o_preamble (o_preamble),
    .o_eof      (o_eof),
    .o_err      (o_err),
    .o_rtcal    (o_rtcal),
    .o_trcal    (o_trcal)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @%0d: observed %0d expected %0d", tag, ptr, obs, exp);
  endtask

  task automatic ps(int iv, int pw = 4, int g = 0);
    sym_t s;
    s.iv = iv; s.pw = pw; s.g = g;
    sq.push_back(s);
  endtask

  // Frame model: works purely on rise times of the envelope seen by the decoder.
  task automatic predict(int d, int rs[$], bit no_eof);
    int tari, rt, gap, last, c;
    if (d < 20 || d > 30 || rs.size() < 2) return;
    tari = rs[1] - rs[0];
    if (tari < 10 || tari > 50) begin e_err[rs[1] + LAT] = 1'b1; return; end
    if (rs.size() < 3) return;
    rt = rs[2] - rs[1];
    if (rt < 2 * tari || rt > 4 * tari) begin e_err[rs[2] + LAT] = 1'b1; return; end
    if (rs.size() < 4) return;
    gap = rs[3] - rs[2];
    c   = rs[3] + LAT;
    e_sof[c] = 1'b1;
    e_rt[c]  = rt;
    if (gap > rt) begin
      e_pre[c] = 1'b1;
      last_tr  = gap;
    end else begin
      e_vld[c] = 1'b1;
      e_bit[c] = (gap > rt / 2);
    end
    e_tr[c] = last_tr;
    last    = rs[3];
    for (int i = 4; i < rs.size(); i++) begin
      gap = rs[i] - last;
      if (gap > rt + 1) break;
      e_vld[rs[i] + LAT] = 1'b1;
      e_bit[rs[i] + LAT] = (gap > rt / 2);
      last = rs[i];
    end
    if (!no_eof) e_eof[last + rt + 1 + LAT] = 1'b1;
  endtask

  task automatic frame(int d, int tail, bit no_eof = 1'b0);
    int rs[$];
    int base;
    repeat (4 + $urandom_range(0, 6)) wave.push_back(1'b1);
    repeat (d) wave.push_back(1'b0);
    rs.push_back(wave.size());
    foreach (sq[i]) begin
      base = wave.size();
      if (sq[i].g > 0) begin
        repeat (sq[i].g) wave.push_back(1'b1);
        wave.push_back(1'b0);
        repeat (sq[i].iv - sq[i].pw - sq[i].g - 1) wave.push_back(1'b1);
        if (!FILT) rs.push_back(base + sq[i].g + 1);
      end else begin
        repeat (sq[i].iv - sq[i].pw) wave.push_back(1'b1);
      end
      repeat (sq[i].pw) wave.push_back(1'b0);
      rs.push_back(wave.size());
    end
    repeat (tail) wave.push_back(1'b1);
    sq.delete();
    predict(d, rs, no_eof);
  endtask

  task automatic play();
    while (ptr < wave.size()) begin
      @(negedge clk);
      chk("strobes", {o_bit_vld, o_sof, o_eof, o_err},
          {e_vld[ptr], e_sof[ptr], e_eof[ptr], e_err[ptr]});
      if (e_vld[ptr]) chk("bit", o_bit, e_bit[ptr]);
      if (e_sof[ptr]) begin
        chk("preamble", o_preamble, e_pre[ptr]);
        chk("rtcal", o_rtcal, e_rt[ptr]);
        chk("trcal", o_trcal, e_tr[ptr]);
      end
      i_pie = wave[ptr];
      ptr++;
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_flags"}, {o_bit, o_bit_vld, o_sof, o_preamble, o_eof, o_err}, 0);
    chk({tag, "_rtcal"}, o_rtcal, 0);
    chk({tag, "_trcal"}, o_trcal, 0);
  endtask

  initial begin
    int tari, d1, rt, kind, nb, d;
    rst   = 1'b1;
    i_pie = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Query-style frame with TRcal, bits 0110
    ps(12); ps(33); ps(80); ps(12); ps(20); ps(20); ps(12); frame(24, 45);
    // Frame-sync: first data symbol decoded with o_sof
    ps(12); ps(33); ps(20); ps(12); ps(20); frame(24, 45);
    // Bad delimiters ignored, then a good frame
    ps(12); ps(33); ps(12); frame(15, 45);
    ps(12); ps(33); ps(12); frame(40, 45);
    ps(12); ps(33); ps(80); ps(20); frame(24, 45);
    // Delimiter limits
    ps(12); ps(33); ps(20); frame(19, 45);
    ps(12); ps(33); ps(20); frame(31, 45);
    ps(12); ps(33); ps(12); ps(20); frame(20, 45);
    ps(12); ps(33); ps(20); ps(12); frame(30, 45);
    // Tari / RTcal range errors and limits
    ps(60); ps(33); ps(12); frame(24, 45);
    ps(12); ps(20); ps(12); frame(24, 45);
    ps(12); ps(49); ps(12); frame(24, 60);
    ps(9);  ps(30); ps(12); frame(24, 45);
    ps(51); ps(120); ps(60); frame(24, 140);
    ps(10); ps(20); ps(10); ps(11); frame(24, 35);
    ps(50); ps(200); ps(50); ps(101); frame(24, 215);
    // Rise at the timeout cycle still decodes; one cycle later is end of frame
    ps(12); ps(33); ps(12); ps(34); frame(24, 45);
    ps(12); ps(33); ps(12); ps(35); frame(24, 45);
    // One-cycle low glitch inside a data-1 symbol
    ps(12); ps(33); ps(80); ps(20, 4, 6); ps(12); frame(24, 45);
    play();

    // Reset in the middle of a frame: outputs clear at once and no o_eof follows
    ps(12); ps(33); ps(80); ps(12); ps(20); frame(24, 8, 1'b1);
    play();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    last_tr = 0;
    repeat (60) wave.push_back(1'b1);
    ps(12); ps(33); ps(20); ps(12); frame(24, 45);
    play();

    // Random frames
    for (int f = 0; f < 30; f++) begin
      tari = $urandom_range(10, 25);
      d1   = tari + $urandom_range(tari / 2, tari);
      rt   = tari + d1;
      kind = $urandom_range(0, 9);
      d    = $urandom_range(20, 30);
      if (kind == 0) d = ($urandom_range(0, 1) == 1) ? $urandom_range(10, 19) : $urandom_range(31, 45);
      if (kind == 1) tari = ($urandom_range(0, 1) == 1) ? $urandom_range(7, 9) : $urandom_range(51, 60);
      if (kind == 2) rt = ($urandom_range(0, 1) == 1) ? 2 * tari - $urandom_range(1, 4)
                                                      : 4 * tari + $urandom_range(1, 4);
      ps(tari, $urandom_range(3, 4));
      ps(rt, $urandom_range(3, 6));
      if ($urandom_range(0, 1) == 1) ps(rt + $urandom_range(1, 2 * rt), $urandom_range(3, 6));
      nb = $urandom_range(1, 8);
      for (int b = 0; b < nb; b++) ps(($urandom_range(0, 1) == 1) ? d1 : tari, $urandom_range(3, 6));
      frame(d, rt + 10 + $urandom_range(0, 10));
      play();
    end
    repeat (20) wave.push_back(1'b1);
    play();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
